// File: rtl/frame_sequencer.sv
// Frame-rate controller: divides CLOCK_50 down to a selectable tick and runs
// each accepted tick as an update phase followed by a render phase.
module frame_sequencer #(
  parameter int unsigned SEL0_COUNT = 1,
  parameter int unsigned SEL1_COUNT = 200000,
  parameter int unsigned SEL2_COUNT = 500000,
  parameter int unsigned SEL3_COUNT = 50000000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [1:0]  select,
  input  logic        pause,
  input  logic        clr_stats,
  input  logic        update_done,
  input  logic        render_done,
  output logic        tick,
  output logic        start_update,
  output logic        start_render,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count
);

  localparam int unsigned DIV_W = 26;

  localparam logic [DIV_W-1:0] RELOAD0 = DIV_W'(SEL0_COUNT);
  localparam logic [DIV_W-1:0] RELOAD1 = DIV_W'(SEL1_COUNT);
  localparam logic [DIV_W-1:0] RELOAD2 = DIV_W'(SEL2_COUNT);
  localparam logic [DIV_W-1:0] RELOAD3 = DIV_W'(SEL3_COUNT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UPD_START = 3'd1,
    UPD_WAIT  = 3'd2,
    RND_START = 3'd3,
    RND_WAIT  = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_count;
  logic [DIV_W-1:0] reload;
  logic             frame_done;
  logic             overrun_hit;

  // select is only looked at when the divider reloads.
  always_comb begin
    unique case (select)
      2'b00:   reload = RELOAD0;
      2'b01:   reload = RELOAD1;
      2'b10:   reload = RELOAD2;
      default: reload = RELOAD3;
    endcase
  end

  // NOTE: async active-low reset in the sensitivity list; all state uses <= so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div_count <= '0;
      tick      <= 1'b0;
    end else if (div_count == '0) begin
      div_count <= reload;
      tick      <= 1'b1;
    end else begin
      div_count <= div_count - 1'b1;
      tick      <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (tick && !pause) state_next = UPD_START;
      UPD_START: state_next = UPD_WAIT;
      UPD_WAIT:  if (update_done) state_next = RND_START;
      RND_START: state_next = RND_WAIT;
      RND_WAIT:  if (render_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign start_update = (state == UPD_START);
  assign start_render = (state == RND_START);
  assign busy         = (state != IDLE);

  assign frame_done  = (state == RND_WAIT) && render_done;
  // A tick arriving on the completing cycle of RND_WAIT is still a drop.
  assign overrun_hit = tick && (state != IDLE) && !pause;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      frame_count   <= '0;
      overrun_count <= '0;
    end else if (clr_stats) begin
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      if (frame_done) frame_count <= frame_count + 1'b1;
      if (overrun_hit && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 1'b1;
    end
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-rate controller for the game loop. Owns the 50 MHz-to-frame-rate divider: the select code chooses the tick period. Each accepted tick runs one frame as two handshaked phases, update then render. It also counts completed frames and dropped (overrun) ticks. It sits between the board clock and the game-logic and VGA-render blocks.

## Interface
- SEL0_COUNT, default 1, reload for select 00 (tick period SEL0_COUNT+1 cycles)
- SEL1_COUNT, default 200000, reload for select 01
- SEL2_COUNT, default 500000, reload for select 10
- SEL3_COUNT, default 50000000, reload for select 11 (1 Hz)
- All reloads must be < 2^26; the divider counter is 26 bits.

Ports:
- CLOCK_50  in  1  system clock, all logic on posedge
- resetn  in  1  asynchronous, active-low reset
- select  in  2  rate code, sampled only at reload
- pause  in  1  level; suppresses frame starts and overrun counting
- clr_stats  in  1  one-cycle clear of frame_count and overrun_count
- update_done  in  1  game logic finished update phase
- render_done  in  1  renderer finished render phase
- tick  out  1  registered one-cycle pulse each divider period
- start_update  out  1  one-cycle pulse starting update phase
- start_render  out  1  one-cycle pulse starting render phase
- busy  out  1  high whenever FSM not IDLE
- frame_count  out  16  completed frames, wraps 0xFFFF→0
- overrun_count  out  8  dropped ticks, saturates at 255

## Operation
- Divider: counter != 0 → decrement, tick<=0. Counter == 0 → tick<=1, counter <= SELn_COUNT for current select. Period = SELn_COUNT+1 cycles. A select change takes effect at the next reload only.
- FSM states: IDLE, UPD_START, UPD_WAIT, RND_START, RND_WAIT.
  - IDLE: tick=1 and pause=0 → UPD_START. Tick with pause=1 is ignored.
  - UPD_START: start_update=1 for this cycle, then → UPD_WAIT. update_done is ignored in this cycle.
  - UPD_WAIT: update_done=1 → RND_START.
  - RND_START: start_render=1 for this cycle, then → RND_WAIT. render_done is ignored in this cycle.
  - RND_WAIT: render_done=1 → IDLE and frame_count+1.
- start_update, start_render and busy decode directly from the state register (Moore).
- Overrun: tick=1 while state != IDLE and pause=0 → overrun_count+1, saturating at 255. The tick is dropped, never queued.
- A tick in the same cycle render_done is accepted in RND_WAIT counts as an overrun.
- pause asserted mid-frame: the current frame completes normally; no new frame starts.
- clr_stats=1 zeroes both counters. It wins over a simultaneous increment.

## Timing
- Reset values: counter=0, tick=0, state=IDLE, start_update=0, start_render=0, busy=0, frame_count=0, overrun_count=0.
- First posedge after resetn rises: counter is 0, so tick=1 in cycle 1.
- Tick high in cycle T (state IDLE, pause=0): start_update and busy high in T+1.
- update_done sampled high in UPD_WAIT at cycle D: start_render high in D+1.
- render_done sampled high in RND_WAIT at cycle R: busy=0 and frame_count updated in R+1.
- Minimum frame length is 4 cycles after tick, with done inputs held high.
- resetn low mid-frame: immediate return to reset values. No start pulses are emitted during reset.

## Test plan
Bench parameters: SEL0=1, SEL1=4, SEL2=9, SEL3=19.
- Rate check: reset, hold select=01, done inputs tied high, run 50 cycles → ticks in cycles 1, 6, 11, … (period 5). Switch to 11 mid-count → new period 20 starts only after the current reload.
- Full frame: select=10, update_done pulses 3 cycles after start_update, render_done 2 cycles after start_render → pulse ordering as specified, busy drops one cycle after render_done, frame_count=1.
- Overrun: select=00, done inputs held low for 20 cycles → overrun_count=9 from ticks in cycles 3…19, frame_count=0. Hold longer → overrun_count stops at 255.
- Pause: pause=1 in IDLE for 3 tick periods → no start_update, overrun_count unchanged. Assert pause mid-frame → that frame completes and frame_count increments.
- Simultaneous: render_done and tick in the same cycle → overrun_count+1, frame_count+1. clr_stats with a frame completion → both counters 0.
- Reset mid-frame: drop resetn during UPD_WAIT → all outputs 0 immediately. After release, tick appears in cycle 1.
